// File: rtl/sdrc_wb_arbiter.sv
// Round-robin Wishbone arbiter in front of the SDRAM controller slave port.
// Ownership lasts a whole wb_cyc; an owner that idles with cyc=1, stb=0 is revoked.
module sdrc_wb_arbiter #(
    parameter int N_MASTERS    = 2,
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int IDLE_TIMEOUT = 256
) (
    input  logic                        sys_clk,
    input  logic                        RESETN,
    input  logic                        sdr_init_done,

    input  logic [N_MASTERS-1:0]        m_cyc_i,
    input  logic [N_MASTERS-1:0]        m_stb_i,
    input  logic [N_MASTERS-1:0]        m_we_i,
    input  logic [N_MASTERS*AW-1:0]     m_addr_i,
    input  logic [N_MASTERS*DW-1:0]     m_dat_i,
    input  logic [N_MASTERS*DW/8-1:0]   m_sel_i,
    input  logic [N_MASTERS*3-1:0]      m_cti_i,
    output logic [N_MASTERS-1:0]        m_ack_o,
    output logic [DW-1:0]               m_dat_o,

    output logic                        wb_cyc_o,
    output logic                        wb_stb_o,
    output logic                        wb_we_o,
    output logic [AW-1:0]               wb_addr_o,
    output logic [DW-1:0]               wb_dat_o,
    output logic [DW/8-1:0]             wb_sel_o,
    output logic [2:0]                  wb_cti_o,
    input  logic                        wb_ack_i,
    input  logic [DW-1:0]               wb_dat_i,

    output logic [N_MASTERS-1:0]        grant_o,
    output logic                        err_o
);

    localparam int SW  = DW / 8;
    localparam int IW  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int WDW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam bit WDOG_EN = (IDLE_TIMEOUT > 0);
    localparam logic [WDW-1:0] WD_LAST  = WDW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
    localparam logic [IW-1:0]  LAST_IDX = IW'(N_MASTERS - 1);
    localparam logic [IW:0]    N_EXT    = (IW+1)'(N_MASTERS);
    localparam logic [N_MASTERS-1:0] ONE_HOT0 = {{(N_MASTERS-1){1'b0}}, 1'b1};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_e;

    state_e                 state_q;
    logic [N_MASTERS-1:0]   grant_q;
    logic [N_MASTERS-1:0]   mask_q;
    logic [IW-1:0]          gidx_q;
    logic [IW-1:0]          rr_ptr_q;
    logic [WDW-1:0]         wdog_q;
    logic                   err_q;

    logic [AW-1:0]          addr_arr [N_MASTERS];
    logic [DW-1:0]          dat_arr  [N_MASTERS];
    logic [SW-1:0]          sel_arr  [N_MASTERS];
    logic [2:0]             cti_arr  [N_MASTERS];

    generate
        for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_slice
            assign addr_arr[gi] = m_addr_i[gi*AW +: AW];
            assign dat_arr[gi]  = m_dat_i[gi*DW +: DW];
            assign sel_arr[gi]  = m_sel_i[gi*SW +: SW];
            assign cti_arr[gi]  = m_cti_i[gi*3 +: 3];
            assign m_ack_o[gi]  = grant_q[gi] & wb_ack_i;
        end
    endgenerate

    // Masked masters stay out of arbitration until they drop cyc once.
    logic [N_MASTERS-1:0]   req;
    logic                   arb_found_d;
    logic [IW-1:0]          arb_idx_d;
    logic [IW:0]            cand;

    assign req = m_cyc_i & ~mask_q;

    // Walk offsets high-to-low so the nearest requester at/after rr_ptr wins.
    always_comb begin
        arb_found_d = 1'b0;
        arb_idx_d   = '0;
        cand        = '0;
        for (int off = N_MASTERS - 1; off >= 0; off--) begin
            cand = {1'b0, rr_ptr_q} + (IW+1)'(off);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (req[cand[IW-1:0]]) begin
                arb_found_d = 1'b1;
                arb_idx_d   = cand[IW-1:0];
            end
        end
    end

    logic                   own;
    logic                   owner_cyc;
    logic                   owner_stb;
    logic [IW-1:0]          rr_next;

    assign own       = |grant_q;
    assign owner_cyc = m_cyc_i[gidx_q];
    assign owner_stb = m_stb_i[gidx_q];
    assign rr_next   = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;

    assign wb_cyc_o  = own & owner_cyc;
    assign wb_stb_o  = own & owner_stb;
    assign wb_we_o   = own & m_we_i[gidx_q];
    assign wb_addr_o = own ? addr_arr[gidx_q] : '0;
    assign wb_dat_o  = own ? dat_arr[gidx_q]  : '0;
    assign wb_sel_o  = own ? sel_arr[gidx_q]  : '0;
    assign wb_cti_o  = own ? cti_arr[gidx_q]  : '0;
    assign m_dat_o   = wb_dat_i;

    assign grant_o   = grant_q;
    assign err_o     = err_q;

    always_ff @(posedge sys_clk) begin
        if (!RESETN) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            mask_q   <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            wdog_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q  <= 1'b0;
            mask_q <= mask_q & m_cyc_i;
            case (state_q)
                S_IDLE: begin
                    wdog_q <= '0;
                    if (sdr_init_done && arb_found_d) begin
                        state_q <= S_OWN;
                        grant_q <= ONE_HOT0 << arb_idx_d;
                        gidx_q  <= arb_idx_d;
                    end
                end
                S_OWN: begin
                    if (!owner_cyc) begin
                        state_q  <= S_IDLE;
                        grant_q  <= '0;
                        rr_ptr_q <= rr_next;
                        wdog_q   <= '0;
                    end else if (owner_stb) begin
                        // A strobed stall waiting for ack is legitimate.
                        wdog_q <= '0;
                    end else if (WDOG_EN && (wdog_q == WD_LAST)) begin
                        state_q        <= S_IDLE;
                        grant_q        <= '0;
                        rr_ptr_q       <= rr_next;
                        wdog_q         <= '0;
                        err_q          <= 1'b1;
                        mask_q[gidx_q] <= 1'b1;
                    end else if (WDOG_EN) begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdrc_wb_arbiter.sv
// Scoreboard bench for sdrc_wb_arbiter: grant sequence, slave transactions and
// watchdog pulses are queued by the stimulus and checked by negedge monitors.
module tb_sdrc_wb_arbiter;

    logic           clk;
    logic           rstn;
    logic           init_done;
    logic [1:0]     m_cyc, m_stb, m_we;
    logic [63:0]    m_addr, m_dat;
    logic [7:0]     m_sel;
    logic [5:0]     m_cti;
    logic [1:0]     m_ack;
    logic [31:0]    m_rdat;
    logic           wb_cyc, wb_stb, wb_we;
    logic [31:0]    wb_addr, wb_wdat;
    logic [3:0]     wb_sel;
    logic [2:0]     wb_cti;
    logic           wb_ack;
    logic [31:0]    wb_rdat;
    logic [1:0]     grant;
    logic           err;

    sdrc_wb_arbiter #(
        .N_MASTERS(2), .AW(32), .DW(32), .IDLE_TIMEOUT(8)
    ) dut (
        .sys_clk(clk), .RESETN(rstn), .sdr_init_done(init_done),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_addr_i(m_addr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_cti_i(m_cti),
        .m_ack_o(m_ack), .m_dat_o(m_rdat),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
        .wb_addr_o(wb_addr), .wb_dat_o(wb_wdat), .wb_sel_o(wb_sel), .wb_cti_o(wb_cti),
        .wb_ack_i(wb_ack), .wb_dat_i(wb_rdat),
        .grant_o(grant), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ack;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] rdat;
        logic [3:0]  sel;
        logic [2:0]  cti;
    } txn_t;

    txn_t        tq[$];
    logic [1:0]  gq[$];
    logic [1:0]  eq[$];
    int          total = 0;
    int          bad = 0;
    bit          mon_en = 1'b0;
    logic [1:0]  prev_g;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] addr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [2:0] cti);
        m_cyc[k] = cyc;
        m_stb[k] = stb;
        m_we[k]  = we;
        m_addr[k*32 +: 32] = addr;
        m_dat[k*32 +: 32]  = dat;
        m_sel[k*4 +: 4]    = sel;
        m_cti[k*3 +: 3]    = cti;
    endtask

    task automatic push_t(input logic [1:0] ack, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdat, input logic [31:0] rdat,
                          input logic [3:0] sel, input logic [2:0] cti);
        txn_t t;
        t.ack = ack; t.we = we; t.addr = addr; t.wdat = wdat;
        t.rdat = rdat; t.sel = sel; t.cti = cti;
        tq.push_back(t);
    endtask

    // Grant-sequence monitor
    always @(negedge clk) begin
        if (mon_en && (grant !== prev_g)) begin
            if (gq.size() == 0) begin
                chk("grant_unexpected", {62'd0, grant}, {62'd0, prev_g});
            end else begin
                chk("grant_seq", {62'd0, grant}, {62'd0, gq.pop_front()});
            end
            prev_g = grant;
        end
    end

    // Watchdog pulse monitor: expected grant at the pulse is queued
    always @(negedge clk) begin
        if (mon_en && err) begin
            if (eq.size() == 0) begin
                chk("err_unexpected", {63'd0, err}, 64'd0);
            end else begin
                chk("err_grant", {62'd0, grant}, {62'd0, eq.pop_front()});
            end
        end
    end

    // Slave transaction monitor
    always @(negedge clk) begin
        if (mon_en && wb_cyc && wb_stb && wb_ack) begin
            if (tq.size() == 0) begin
                chk("txn_unexpected", {32'd0, wb_addr}, 64'd0);
            end else begin
                txn_t t;
                t = tq.pop_front();
                $display("txn ack=%b we=%0d addr=%h cti=%b", m_ack, wb_we, wb_addr, wb_cti);
                chk("txn_ack",  {62'd0, m_ack}, {62'd0, t.ack});
                chk("txn_we",   {63'd0, wb_we}, {63'd0, t.we});
                chk("txn_addr", {32'd0, wb_addr}, {32'd0, t.addr});
                chk("txn_sel",  {60'd0, wb_sel}, {60'd0, t.sel});
                chk("txn_cti",  {61'd0, wb_cti}, {61'd0, t.cti});
                if (t.we) chk("txn_wdat", {32'd0, wb_wdat}, {32'd0, t.wdat});
                else      chk("txn_rdat", {32'd0, m_rdat},  {32'd0, t.rdat});
            end
        end
    end

    initial begin
        rstn = 1'b0; init_done = 1'b0;
        m_cyc = '0; m_stb = '0; m_we = '0; m_addr = '0; m_dat = '0; m_sel = '0; m_cti = '0;
        wb_ack = 1'b0; wb_rdat = '0;
        tick(); tick();
        chk("reset_grant", {62'd0, grant}, 64'd0);
        chk("reset_err", {63'd0, err}, 64'd0);
        chk("reset_cyc", {63'd0, wb_cyc}, 64'd0);
        chk("reset_ack", {62'd0, m_ack}, 64'd0);
        rstn = 1'b1;
        tick();
        prev_g = grant;
        mon_en = 1'b1;

        // No grant while SDRAM init is pending; latency 1 once it completes
        set_m(0, 1, 0, 0, 32'h0, 32'h0, 4'hF, 3'b000);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("init_wait_grant", {62'd0, grant}, 64'd0);
        end
        gq.push_back(2'b01);
        init_done = 1'b1;
        tick();
        chk("init_latency", {62'd0, grant}, 64'd1);

        // M0 single write, M1 read after one idle cycle
        set_m(0, 1, 1, 1, 32'h100, 32'hA5A5A5A5, 4'hF, 3'b000);
        set_m(1, 1, 1, 0, 32'h200, 32'h0, 4'hF, 3'b000);
        wb_ack = 1'b1;
        push_t(2'b01, 1'b1, 32'h100, 32'hA5A5A5A5, 32'h0, 4'hF, 3'b000);
        tick();
        wb_ack = 1'b0;
        set_m(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 3'b000);
        gq.push_back(2'b00); gq.push_back(2'b10);
        tick();
        chk("idle_gap", {62'd0, grant}, 64'd0);
        tick();
        chk("m1_grant", {62'd0, grant}, 64'd2);
        wb_ack = 1'b1; wb_rdat = 32'h12345678;
        push_t(2'b10, 1'b0, 32'h200, 32'h0, 32'h12345678, 4'hF, 3'b000);
        tick();
        wb_ack = 1'b0;
        set_m(1, 0, 0, 0, 32'h0, 32'h0, 4'h0, 3'b000);
        gq.push_back(2'b00);
        tick();
        chk("m1_release", {62'd0, grant}, 64'd0);

        // M0 4-beat incrementing burst while M1 waits
        set_m(0, 1, 1, 1, 32'h300, 32'h11110000, 4'hF, 3'b010);
        set_m(1, 1, 1, 1, 32'h500, 32'hCAFE0001, 4'hF, 3'b000);
        gq.push_back(2'b01);
        tick();
        chk("burst_grant", {62'd0, grant}, 64'd1);
        for (int b = 0; b < 4; b++) begin
            set_m(0, 1, 1, 1, 32'h300 + 32'(4*b), 32'h11110000 + 32'(b), 4'hF,
                  (b == 3) ? 3'b111 : 3'b010);
            wb_ack = 1'b1;
            push_t(2'b01, 1'b1, 32'h300 + 32'(4*b), 32'h11110000 + 32'(b), 32'h0, 4'hF,
                   (b == 3) ? 3'b111 : 3'b010);
            tick();
            chk("burst_hold", {62'd0, grant}, 64'd1);
        end
        wb_ack = 1'b0;
        set_m(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 3'b000);
        gq.push_back(2'b00); gq.push_back(2'b10);
        tick();
        chk("burst_release", {62'd0, grant}, 64'd0);
        tick();
        chk("burst_next_m1", {62'd0, grant}, 64'd2);
        set_m(0, 1, 0, 0, 32'h0, 32'h0, 4'hF, 3'b000);
        wb_ack = 1'b1;
        push_t(2'b10, 1'b1, 32'h500, 32'hCAFE0001, 32'h0, 4'hF, 3'b000);
        tick();
        wb_ack = 1'b0;
        set_m(1, 0, 0, 0, 32'h0, 32'h0, 4'h0, 3'b000);
        gq.push_back(2'b00); gq.push_back(2'b01);
        tick();
        chk("rr_idle", {62'd0, grant}, 64'd0);
        tick();
        chk("rr_m0_after_m1", {62'd0, grant}, 64'd1);
        set_m(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 3'b000);
        gq.push_back(2'b00);
        tick();
        chk("rr_m0_release", {62'd0, grant}, 64'd0);

        // Watchdog: M0 holds cyc with stb low
        set_m(0, 1, 0, 0, 32'h600, 32'h0, 4'hF, 3'b000);
        gq.push_back(2'b01);
        tick();
        chk("wd_grant", {62'd0, grant}, 64'd1);
        set_m(1, 1, 0, 0, 32'h0, 32'h0, 4'hF, 3'b000);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("wd_quiet_err", {63'd0, err}, 64'd0);
            chk("wd_quiet_grant", {62'd0, grant}, 64'd1);
        end
        gq.push_back(2'b00); eq.push_back(2'b00); gq.push_back(2'b10);
        tick();
        chk("wd_err", {63'd0, err}, 64'd1);
        chk("wd_revoke", {62'd0, grant}, 64'd0);
        tick();
        chk("wd_err_one_cycle", {63'd0, err}, 64'd0);
        chk("wd_next_m1", {62'd0, grant}, 64'd2);
        set_m(1, 0, 0, 0, 32'h0, 32'h0, 4'h0, 3'b000);
        gq.push_back(2'b00);
        tick();
        chk("wd_m1_release", {62'd0, grant}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("wd_masked", {62'd0, grant}, 64'd0);
        end
        set_m(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 3'b000);
        tick();
        chk("wd_unmask_idle", {62'd0, grant}, 64'd0);
        set_m(0, 1, 1, 0, 32'h700, 32'h0, 4'hF, 3'b000);
        gq.push_back(2'b01);
        tick();
        chk("wd_regrant", {62'd0, grant}, 64'd1);

        // Strobed stall of 300 cycles is never counted by the watchdog
        for (int i = 0; i < 300; i++) tick();
        chk("stall_hold", {62'd0, grant}, 64'd1);
        wb_ack = 1'b1; wb_rdat = 32'hDEADBEEF;
        push_t(2'b01, 1'b0, 32'h700, 32'h0, 32'hDEADBEEF, 4'hF, 3'b000);
        tick();
        wb_ack = 1'b0;
        set_m(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 3'b000);
        gq.push_back(2'b00);
        tick();
        chk("stall_release", {62'd0, grant}, 64'd0);

        // Reset in the middle of an M1 burst
        set_m(1, 1, 1, 1, 32'h800, 32'hBEEF0000, 4'hF, 3'b010);
        gq.push_back(2'b10);
        tick();
        chk("rst_burst_grant", {62'd0, grant}, 64'd2);
        wb_ack = 1'b1;
        push_t(2'b10, 1'b1, 32'h800, 32'hBEEF0000, 32'h0, 4'hF, 3'b010);
        tick();
        wb_ack = 1'b0;
        set_m(1, 1, 1, 1, 32'h804, 32'hBEEF0001, 4'hF, 3'b010);
        tick();
        rstn = 1'b0;
        set_m(0, 1, 0, 0, 32'h900, 32'h0, 4'hF, 3'b000);
        gq.push_back(2'b00);
        tick();
        chk("rst_grant", {62'd0, grant}, 64'd0);
        chk("rst_cyc", {63'd0, wb_cyc}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        rstn = 1'b1;
        gq.push_back(2'b01);
        tick();
        chk("rst_rr_m0", {62'd0, grant}, 64'd1);
        set_m(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 3'b000);
        set_m(1, 0, 0, 0, 32'h0, 32'h0, 4'h0, 3'b000);
        gq.push_back(2'b00);
        tick();
        chk("final_idle", {62'd0, grant}, 64'd0);
        tick(); tick();

        chk("grant_q_drained", 64'(gq.size()), 64'd0);
        chk("txn_q_drained", 64'(tq.size()), 64'd0);
        chk("err_q_drained", 64'(eq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
